pr_hrav_dispatcher: RTL and testbench
=====================================

// Module: pr_hrav_dispatcher
// PURPOSE
//  Receives packets from S/W via RX DMA (single AXI4-Stream slave) and routes each packet
//  to scanner core 0, scanner core 1 or the ICAP controller (three AXI4-Stream masters).
//  Routing is decided on the first cell and held until TLAST. Packets to a disabled core
//  (PR de-coupling) or to an invalid destination are consumed and dropped.
//  Counterpart of the TX-side collector.
// PARAMETERS
//  C_S_AXIS_DATA_WIDTH  256  slave TDATA width (TSTRB = /8)
//  C_M_AXIS_DATA_WIDTH  256  master TDATA width; must equal C_S_AXIS_DATA_WIDTH
//  C_DEST_LSB           0    LSB of 2-bit destination field in head-cell TUSER
//  C_CNT_WIDTH          16   width of drop counter
// PORTS
//  ACLK                 in   1    clock; all logic rising-edge
//  ARESET               in   1    synchronous active-high reset
//  core_0_enb           in   1    1 = core 0 attached; 0 = de-coupled (reconfiguring)
//  core_1_enb           in   1    same for core 1
//  S_AXIS_TDATA/TSTRB/TUSER[127:0]/TVALID/TLAST in, TREADY out  from RX DMA
//  CORE0_M_AXIS_TDATA/TSTRB/TUSER[127:0]/TVALID/TLAST out, TREADY in  to core 0
//  CORE1_M_AXIS_*       same set, to core 1
//  ICAP_M_AXIS_*        same set, to ICAP controller
//  drop_cnt             out  C_CNT_WIDTH  packets dropped/truncated, saturating
// BEHAVIOUR
//  - Input: 2-entry skid buffer on {TLAST,TUSER,TSTRB,TDATA}. S_AXIS_TREADY = buffer not full
//    (registered). Min latency: cell accepted in cycle N is presented to masters in N+1.
//    Full throughput (1 cell/cycle) when the selected master holds TREADY=1.
//  - Dest decode (head cell only): TUSER[C_DEST_LSB+:2] 00=core0, 01=core1, 10=icap, 11=invalid.
//  - FSM states: IDLE, FWD (dest latched in 3-bit one-hot sel), DROP.
//    IDLE: head valid & dest enabled -> present to dest; on handshake with TLAST=0 -> FWD,
//      TLAST=1 -> stay IDLE. Head to disabled core or dest 11 -> consume the head cell this cycle
//      (internal ready=1); TLAST=0 -> DROP, TLAST=1 -> IDLE + drop_cnt++.
//    FWD: only sel master may assert TVALID; handshake with TLAST=1 -> IDLE.
//      Enable of sel core drops to 0 mid-packet -> that TVALID forced 0 same cycle
//      (combinational), go DROP, drop_cnt++ once; remainder of packet discarded.
//    DROP: consume 1 cell/cycle regardless of master TREADY; TLAST=1 -> IDLE
//      (drop_cnt++ on entry paths from IDLE only, counted at TLAST).
//  - Masters: TDATA/TSTRB/TUSER/TLAST of buffer head fanned out to all three; only TVALID
//    is gated: Mx_TVALID = head_valid & sel[x] & enb[x] (icap enb = 1). Unselected TREADY ignored.
//  - No arbitration: one packet in flight; head-of-line blocks while sel master TREADY=0.
//  - TVALID, once asserted, holds with stable data until TREADY (AXI rule), except forced
//    deassert on enable loss.
//  - drop_cnt saturates at all-ones; no wrap.
//  - Reset (any time, incl. mid-packet): state IDLE, buffer emptied, all M TVALID=0,
//    S_AXIS_TREADY=0 during reset and 1 the cycle after, drop_cnt=0; in-flight packet lost,
//    next accepted cell is treated as a head cell.
//  - Simultaneous: TLAST handshake and enable loss same cycle -> TVALID already 0, so packet
//    goes to DROP path; S_AXIS accept and head dequeue same cycle -> occupancy unchanged.
// TESTING
//  1 Single-cell pkts dest 00,01,10 back-to-back, all TREADY=1 -> one cell each on CORE0,
//    CORE1, ICAP in order, 1 cycle after accept, S_AXIS_TREADY stays 1, drop_cnt=0.
//  2 4-cell pkt to core1, CORE1 TREADY toggles 1/0 each cycle -> 4 cells, data stable
//    while stalled, CORE0/ICAP TVALID never 1, TLAST only on 4th cell.
//  3 core_0_enb=0, 3-cell pkt dest 00 then 1-cell pkt dest 10 -> no CORE0 TVALID,
//    drop_cnt=1, ICAP gets 1 cell.
//  4 5-cell pkt to core0, core_0_enb falls after cell 2 handshake -> CORE0 sees 2 cells no
//    TLAST, cells 3-5 consumed, drop_cnt=1, following pkt routes normally.
//  5 Dest 11, 2-cell pkt -> drained in 2 cycles, drop_cnt=1; force 2^C_CNT_WIDTH+3 drops ->
//    drop_cnt=all-ones.
//  6 ARESET pulsed mid 6-cell FWD pkt -> all TVALID=0 next cycle, drop_cnt=0, next pkt
//    routed by its own head TUSER.

Source files
------------

// File: rtl/pr_hrav_dispatcher.sv
// pr_hrav_dispatcher: routes RX DMA packets to scanner core 0, core 1 or the ICAP controller.
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   core_0_enb, core_1_enb 1 = core attached, 0 = de-coupled for partial reconfiguration
//   S_AXIS_*               AXI4-Stream slave from RX DMA (TDATA/TSTRB/TUSER/TVALID/TLAST, TREADY out)
//   CORE0_M_AXIS_*         AXI4-Stream master to scanner core 0
//   CORE1_M_AXIS_*         AXI4-Stream master to scanner core 1
//   ICAP_M_AXIS_*          AXI4-Stream master to ICAP controller
//   drop_cnt               saturating count of dropped / truncated packets
module pr_hrav_dispatcher #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH = 256,
  parameter int unsigned C_M_AXIS_DATA_WIDTH = 256,
  parameter int unsigned C_DEST_LSB          = 0,
  parameter int unsigned C_CNT_WIDTH         = 16
) (
  input  logic                                 ACLK,
  input  logic                                 ARESET,
  input  logic                                 core_0_enb,
  input  logic                                 core_1_enb,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
  input  logic [127:0]                         S_AXIS_TUSER,
  input  logic                                 S_AXIS_TVALID,
  input  logic                                 S_AXIS_TLAST,
  output logic                                 S_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       CORE0_M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     CORE0_M_AXIS_TSTRB,
  output logic [127:0]                         CORE0_M_AXIS_TUSER,
  output logic                                 CORE0_M_AXIS_TVALID,
  output logic                                 CORE0_M_AXIS_TLAST,
  input  logic                                 CORE0_M_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       CORE1_M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     CORE1_M_AXIS_TSTRB,
  output logic [127:0]                         CORE1_M_AXIS_TUSER,
  output logic                                 CORE1_M_AXIS_TVALID,
  output logic                                 CORE1_M_AXIS_TLAST,
  input  logic                                 CORE1_M_AXIS_TREADY,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]       ICAP_M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     ICAP_M_AXIS_TSTRB,
  output logic [127:0]                         ICAP_M_AXIS_TUSER,
  output logic                                 ICAP_M_AXIS_TVALID,
  output logic                                 ICAP_M_AXIS_TLAST,
  input  logic                                 ICAP_M_AXIS_TREADY,

  output logic [C_CNT_WIDTH-1:0]               drop_cnt
);

  localparam int unsigned DW  = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW  = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned MDW = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned MSW = C_M_AXIS_DATA_WIDTH / 8;
  localparam int unsigned UW  = 128;
  localparam int unsigned CW  = 1 + UW + SW + DW;

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  // Two-entry skid buffer holding {last, user, strb, data}
  logic [CW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [1:0]    count_next;
  logic          s_acc;
  logic          pop;

  logic [CW-1:0] head;
  logic          head_valid;
  logic          head_last;
  logic [UW-1:0] head_user;
  logic [SW-1:0] head_strb;
  logic [DW-1:0] head_data;
  logic [1:0]    head_dest;
  logic [2:0]    head_sel;

  state_t        state;
  logic [2:0]    sel_q;
  logic          drop_at_last;
  logic [2:0]    enb_vec;
  logic [2:0]    m_tready;
  logic [2:0]    m_tvalid;
  logic [2:0]    sel_c;
  logic          sel_lost;
  logic [C_CNT_WIDTH-1:0] drop_cnt_inc;

  assign s_acc      = S_AXIS_TVALID & S_AXIS_TREADY;
  assign count_next = count + 2'(s_acc) - 2'(pop);

  assign head       = mem[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign head_last  = head[CW-1];
  assign head_user  = head[DW+SW+UW-1 : DW+SW];
  assign head_strb  = head[DW+SW-1 : DW];
  assign head_data  = head[DW-1:0];
  assign head_dest  = head_user[C_DEST_LSB +: 2];

  // Buffer storage needs no reset; occupancy and pointers do
  always_ff @(posedge ACLK) begin
    if (s_acc) mem[wr_ptr] <= {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
  end

  // Buffer pointers, occupancy and registered slave ready
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      count         <= 2'd0;
      S_AXIS_TREADY <= 1'b0;
    end else begin
      if (s_acc) wr_ptr <= ~wr_ptr;
      if (pop)   rd_ptr <= ~rd_ptr;
      count         <= count_next;
      S_AXIS_TREADY <= (count_next != 2'd2);
    end
  end

  // Head-cell destination decode; code 11 selects nothing
  always_comb begin
    head_sel = 3'b000;
    case (head_dest)
      2'b00:   head_sel = 3'b001;
      2'b01:   head_sel = 3'b010;
      2'b10:   head_sel = 3'b100;
      default: head_sel = 3'b000;
    endcase
  end

  assign enb_vec  = {1'b1, core_1_enb, core_0_enb};
  assign m_tready = {ICAP_M_AXIS_TREADY, CORE1_M_AXIS_TREADY, CORE0_M_AXIS_TREADY};

  // Master select, dequeue and enable-loss detection for the current state
  always_comb begin
    sel_c    = 3'b000;
    pop      = 1'b0;
    sel_lost = 1'b0;
    case (state)
      IDLE: begin
        sel_c = head_sel;
        if (head_valid) begin
          if ((head_sel & enb_vec) == 3'b000) pop = 1'b1;
          else                                pop = |(head_sel & m_tready);
        end
      end
      FWD: begin
        sel_lost = ((sel_q & enb_vec) == 3'b000);
        if (!sel_lost) begin
          sel_c = sel_q;
          pop   = head_valid & (|(sel_q & m_tready));
        end
      end
      DROP: pop = head_valid;
      default: ;
    endcase
  end

  // Valid is the only gated master signal; enable loss masks it immediately
  assign m_tvalid = {3{head_valid}} & sel_c & enb_vec;

  assign drop_cnt_inc = (&drop_cnt) ? drop_cnt : drop_cnt + C_CNT_WIDTH'(1);

  // Packet routing FSM and drop counter
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state        <= IDLE;
      sel_q        <= 3'b000;
      drop_at_last <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            if ((head_sel & enb_vec) == 3'b000) begin
              if (head_last) begin
                drop_cnt <= drop_cnt_inc;
              end else begin
                state        <= DROP;
                drop_at_last <= 1'b1;
              end
            end else if (!head_last) begin
              state <= FWD;
              sel_q <= head_sel;
            end
          end
        end
        FWD: begin
          if (sel_lost) begin
            // Truncated packet is counted now, not again at its TLAST
            state        <= DROP;
            drop_at_last <= 1'b0;
            drop_cnt     <= drop_cnt_inc;
          end else if (pop && head_last) begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (pop && head_last) begin
            state <= IDLE;
            if (drop_at_last) drop_cnt <= drop_cnt_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head cell fanned out to every master
  assign CORE0_M_AXIS_TDATA  = MDW'(head_data);
  assign CORE0_M_AXIS_TSTRB  = MSW'(head_strb);
  assign CORE0_M_AXIS_TUSER  = head_user;
  assign CORE0_M_AXIS_TLAST  = head_last;
  assign CORE0_M_AXIS_TVALID = m_tvalid[0];

  assign CORE1_M_AXIS_TDATA  = MDW'(head_data);
  assign CORE1_M_AXIS_TSTRB  = MSW'(head_strb);
  assign CORE1_M_AXIS_TUSER  = head_user;
  assign CORE1_M_AXIS_TLAST  = head_last;
  assign CORE1_M_AXIS_TVALID = m_tvalid[1];

  assign ICAP_M_AXIS_TDATA   = MDW'(head_data);
  assign ICAP_M_AXIS_TSTRB   = MSW'(head_strb);
  assign ICAP_M_AXIS_TUSER   = head_user;
  assign ICAP_M_AXIS_TLAST   = head_last;
  assign ICAP_M_AXIS_TVALID  = m_tvalid[2];

endmodule

// File: tb/tb_pr_hrav_dispatcher.sv
// tb_pr_hrav_dispatcher: directed stimulus with a scoreboard queue and an output monitor
// for pr_hrav_dispatcher.
`timescale 1ns/1ps
module tb_pr_hrav_dispatcher;

  localparam int unsigned DW   = 256;
  localparam int unsigned SW   = 32;
  localparam int unsigned CNTW = 16;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic            core_0_enb = 1'b1;
  logic            core_1_enb = 1'b1;

  logic [DW-1:0]   S_AXIS_TDATA = '0;
  logic [SW-1:0]   S_AXIS_TSTRB = '0;
  logic [127:0]    S_AXIS_TUSER = '0;
  logic            S_AXIS_TVALID = 1'b0;
  logic            S_AXIS_TLAST = 1'b0;
  logic            S_AXIS_TREADY;

  logic [DW-1:0]   CORE0_M_AXIS_TDATA, CORE1_M_AXIS_TDATA, ICAP_M_AXIS_TDATA;
  logic [SW-1:0]   CORE0_M_AXIS_TSTRB, CORE1_M_AXIS_TSTRB, ICAP_M_AXIS_TSTRB;
  logic [127:0]    CORE0_M_AXIS_TUSER, CORE1_M_AXIS_TUSER, ICAP_M_AXIS_TUSER;
  logic            CORE0_M_AXIS_TVALID, CORE1_M_AXIS_TVALID, ICAP_M_AXIS_TVALID;
  logic            CORE0_M_AXIS_TLAST, CORE1_M_AXIS_TLAST, ICAP_M_AXIS_TLAST;
  logic            CORE0_M_AXIS_TREADY = 1'b1;
  logic            CORE1_M_AXIS_TREADY;
  logic            ICAP_M_AXIS_TREADY = 1'b1;
  logic [CNTW-1:0] drop_cnt;

  // Core 1 ready is either a static level or a per-cycle toggle
  logic c1_rdy_base = 1'b1;
  logic tog_en = 1'b0;
  logic tog_ph = 1'b1;
  assign CORE1_M_AXIS_TREADY = tog_en ? tog_ph : c1_rdy_base;
  always @(posedge ACLK) begin
    #1;
    if (tog_en) tog_ph = ~tog_ph;
    else        tog_ph = 1'b1;
  end

  always #5 ACLK = ~ACLK;

  pr_hrav_dispatcher dut (
    .ACLK(ACLK), .ARESET(ARESET), .core_0_enb(core_0_enb), .core_1_enb(core_1_enb),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
    .CORE0_M_AXIS_TDATA(CORE0_M_AXIS_TDATA), .CORE0_M_AXIS_TSTRB(CORE0_M_AXIS_TSTRB),
    .CORE0_M_AXIS_TUSER(CORE0_M_AXIS_TUSER), .CORE0_M_AXIS_TVALID(CORE0_M_AXIS_TVALID),
    .CORE0_M_AXIS_TLAST(CORE0_M_AXIS_TLAST), .CORE0_M_AXIS_TREADY(CORE0_M_AXIS_TREADY),
    .CORE1_M_AXIS_TDATA(CORE1_M_AXIS_TDATA), .CORE1_M_AXIS_TSTRB(CORE1_M_AXIS_TSTRB),
    .CORE1_M_AXIS_TUSER(CORE1_M_AXIS_TUSER), .CORE1_M_AXIS_TVALID(CORE1_M_AXIS_TVALID),
    .CORE1_M_AXIS_TLAST(CORE1_M_AXIS_TLAST), .CORE1_M_AXIS_TREADY(CORE1_M_AXIS_TREADY),
    .ICAP_M_AXIS_TDATA(ICAP_M_AXIS_TDATA), .ICAP_M_AXIS_TSTRB(ICAP_M_AXIS_TSTRB),
    .ICAP_M_AXIS_TUSER(ICAP_M_AXIS_TUSER), .ICAP_M_AXIS_TVALID(ICAP_M_AXIS_TVALID),
    .ICAP_M_AXIS_TLAST(ICAP_M_AXIS_TLAST), .ICAP_M_AXIS_TREADY(ICAP_M_AXIS_TREADY),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    int            port;
    logic [DW-1:0] data;
    logic          last;
    longint        t_exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [2:0]    mv, mr, ml, enb_now;
  logic [DW-1:0] md [3];
  assign mv = {ICAP_M_AXIS_TVALID, CORE1_M_AXIS_TVALID, CORE0_M_AXIS_TVALID};
  assign mr = {ICAP_M_AXIS_TREADY, CORE1_M_AXIS_TREADY, CORE0_M_AXIS_TREADY};
  assign ml = {ICAP_M_AXIS_TLAST, CORE1_M_AXIS_TLAST, CORE0_M_AXIS_TLAST};
  assign md[0] = CORE0_M_AXIS_TDATA;
  assign md[1] = CORE1_M_AXIS_TDATA;
  assign md[2] = ICAP_M_AXIS_TDATA;
  assign enb_now = {1'b1, core_1_enb, core_0_enb};

  function automatic logic [DW-1:0] mk_data(input int id);
    return {8{32'(id) ^ 32'hC0DE_0000}};
  endfunction

  // Monitor: routing, payload, latency and stall-hold checks on every master
  logic [2:0]    pv = '0, pr = '0, pl = '0;
  logic [DW-1:0] pd [3];
  exp_t          e;
  always @(negedge ACLK) begin
    if (!ARESET) begin
      for (int p = 0; p < 3; p++) begin
        if (mv[p]) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL route: valid on port %0d, scoreboard expects nothing", p);
          end else if (sb[0].port != p) begin
            errors++;
            $display("FAIL route: valid on port %0d, required port %0d", p, sb[0].port);
          end else if (mr[p]) begin
            e = sb.pop_front();
            checks++;
            if (md[p] !== e.data || ml[p] !== e.last) begin
              errors++;
              $display("FAIL cell port %0d: data %h last %0b, required data %h last %0b",
                       p, md[p][31:0], ml[p], e.data[31:0], e.last);
            end
            if (e.t_exp != 0) begin
              checks++;
              if (longint'($time) + 5 != e.t_exp) begin
                errors++;
                $display("FAIL latency port %0d: handshake at %0t, required %0d", p, $time + 5, e.t_exp);
              end
            end
          end
        end
        if (pv[p] && !pr[p] && enb_now[p]) begin
          checks++;
          if (!mv[p] || md[p] !== pd[p] || ml[p] !== pl[p]) begin
            errors++;
            $display("FAIL hold port %0d: valid %0b data %h, required valid 1 data %h",
                     p, mv[p], md[p][31:0], pd[p][31:0]);
          end
        end
        pv[p] = mv[p];
        pr[p] = mr[p];
        pl[p] = ml[p];
        pd[p] = md[p];
      end
    end else begin
      pv = '0;
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Drive one cell; port < 0 means the cell must not appear on any master
  task automatic send_cell(input int id, input logic [1:0] dest, input logic last,
                           input int port, input bit chk_rdy, input bit chk_lat);
    exp_t x;
    int   n;
    if (port >= 0) begin
      x.port = port; x.data = mk_data(id); x.last = last; x.t_exp = 0;
      sb.push_back(x);
    end
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b1;
    S_AXIS_TDATA  = mk_data(id);
    S_AXIS_TSTRB  = '1;
    S_AXIS_TUSER  = {126'(id), dest};
    S_AXIS_TLAST  = last;
    n = 0;
    while (!S_AXIS_TREADY && n < 1000) begin
      @(negedge ACLK);
      n++;
    end
    if (!S_AXIS_TREADY) begin
      errors++;
      $display("FAIL s_tready timeout: cell %0d never accepted", id);
    end
    if (chk_rdy) begin
      checks++;
      if (n != 0) begin
        errors++;
        $display("FAIL s_tready_steady: cell %0d waited %0d cycles, required 0", id, n);
      end
    end
    @(posedge ACLK);
    if (port >= 0 && chk_lat) sb[sb.size()-1].t_exp = longint'($time) + 10;
  endtask

  task automatic idle_in();
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge ACLK);
      n++;
    end
    chk({name, "_drained"}, sb.size(), 0);
    repeat (4) @(negedge ACLK);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1;
    @(posedge ACLK);
    #1 sb.delete();
    @(negedge ACLK);
    chk("rst_s_tready", S_AXIS_TREADY, 0);
    chk("rst_m_tvalid", mv, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("post_rst_s_tready", S_AXIS_TREADY, 1);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // 1: single-cell packets to core0, core1, icap back to back
    send_cell(1, 2'b00, 1'b1, 0, 1'b1, 1'b1);
    send_cell(2, 2'b01, 1'b1, 1, 1'b1, 1'b1);
    send_cell(3, 2'b10, 1'b1, 2, 1'b1, 1'b1);
    idle_in();
    drain("t1");
    chk("t1_drop_cnt", drop_cnt, 0);

    // 2: 4-cell packet to core1 with toggling ready; body TUSER dest bits are 11
    tog_en = 1'b1;
    send_cell(10, 2'b01, 1'b0, 1, 1'b0, 1'b0);
    send_cell(11, 2'b11, 1'b0, 1, 1'b0, 1'b0);
    send_cell(12, 2'b11, 1'b0, 1, 1'b0, 1'b0);
    send_cell(13, 2'b11, 1'b1, 1, 1'b0, 1'b0);
    idle_in();
    drain("t2");
    tog_en = 1'b0;
    chk("t2_drop_cnt", drop_cnt, 0);

    // 3: core0 de-coupled, 3-cell packet dropped, icap packet passes
    core_0_enb = 1'b0;
    send_cell(20, 2'b00, 1'b0, -1, 1'b0, 1'b0);
    send_cell(21, 2'b00, 1'b0, -1, 1'b0, 1'b0);
    send_cell(22, 2'b00, 1'b1, -1, 1'b0, 1'b0);
    send_cell(23, 2'b10, 1'b1, 2, 1'b0, 1'b0);
    idle_in();
    drain("t3");
    chk("t3_drop_cnt", drop_cnt, 1);
    core_0_enb = 1'b1;
    do_reset();

    // 4: core0 enable falls after second cell handshake of a 5-cell packet
    fork
      begin : kill_enb
        int hs;
        int n;
        hs = 0;
        n = 0;
        while (hs < 2 && n < 500) begin
          @(negedge ACLK);
          if (CORE0_M_AXIS_TVALID && CORE0_M_AXIS_TREADY) hs++;
          n++;
        end
        chk("t4_core0_hs_seen", hs, 2);
        @(posedge ACLK);
        #1 core_0_enb = 1'b0;
      end
      begin : t4_stim
        send_cell(30, 2'b00, 1'b0, 0, 1'b0, 1'b0);
        send_cell(31, 2'b11, 1'b0, 0, 1'b0, 1'b0);
        send_cell(32, 2'b11, 1'b0, -1, 1'b0, 1'b0);
        send_cell(33, 2'b11, 1'b0, -1, 1'b0, 1'b0);
        send_cell(34, 2'b11, 1'b1, -1, 1'b0, 1'b0);
        send_cell(35, 2'b01, 1'b1, 1, 1'b0, 1'b0);
        idle_in();
      end
    join
    drain("t4");
    chk("t4_drop_cnt", drop_cnt, 1);
    core_0_enb = 1'b1;
    do_reset();

    // 5: invalid destination, then saturate the drop counter
    send_cell(40, 2'b11, 1'b0, -1, 1'b1, 1'b0);
    send_cell(41, 2'b00, 1'b1, -1, 1'b1, 1'b0);
    idle_in();
    repeat (3) @(negedge ACLK);
    chk("t5_drop_cnt_one", drop_cnt, 1);
    for (int i = 0; i < 65539; i++) send_cell(1000 + i, 2'b11, 1'b1, -1, 1'b0, 1'b0);
    idle_in();
    repeat (4) @(negedge ACLK);
    chk("t5_drop_cnt_sat", drop_cnt, 65535);

    // 6: reset in the middle of a 6-cell packet forwarded to core1
    send_cell(50, 2'b01, 1'b0, 1, 1'b0, 1'b0);
    send_cell(51, 2'b11, 1'b0, 1, 1'b0, 1'b0);
    send_cell(52, 2'b11, 1'b0, 1, 1'b0, 1'b0);
    idle_in();
    drain("t6a");
    @(negedge ACLK);
    c1_rdy_base = 1'b0;
    send_cell(53, 2'b11, 1'b0, 1, 1'b0, 1'b0);
    idle_in();
    repeat (2) @(negedge ACLK);
    do_reset();
    c1_rdy_base = 1'b1;
    send_cell(60, 2'b10, 1'b1, 2, 1'b1, 1'b1);
    idle_in();
    drain("t6b");
    chk("t6_drop_cnt", drop_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
